// File: rtl/rx_fifo_prog.sv
// Parametrised single-clock receive FIFO for the UART RX path.
// Offers registered or first-word-fall-through reads, programmable watermarks and sticky error flags.
module rx_fifo_prog #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter bit FWFT       = 1'b0,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  flush,
   input  logic                  clr_err,
   input  logic [AW:0]           af_thresh,
   input  logic [AW:0]           ae_thresh,
   output logic [AW:0]           count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  ovf_sticky,
   output logic                  udf_sticky
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  rd_ok;
   logic                  wr_ok;
   logic                  wr_do;
   logic                  rd_do;

   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= af_thresh);
   assign almost_empty = (count <= ae_thresh);

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   assign rd_ok = rd_en & ~empty;
   assign wr_ok = wr_en & (~full | rd_ok);
   assign wr_do = wr_ok & ~flush;
   assign rd_do = rd_ok & ~flush;

   // NOTE: storage has no reset; stale words are unreachable once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (wr_do) mem[wr_ptr] <= data_in;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         wr_ack     <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
         ovf_sticky <= 1'b0;
         udf_sticky <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         wr_ack     <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
         ovf_sticky <= 1'b0;
         udf_sticky <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         wr_ack     <= wr_ok;
         overflow   <= wr_en & ~wr_ok;
         underflow  <= rd_en & ~rd_ok;
         // A new error in the same cycle as clr_err keeps the flag set.
         ovf_sticky <= (wr_en & ~wr_ok) | (ovf_sticky & ~clr_err);
         udf_sticky <= (rd_en & ~rd_ok) | (udf_sticky & ~clr_err);
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Head word is presented directly; forced to zero while empty so reset shows a clean bus.
         assign data_out   = empty ? '0 : mem[rd_ptr];
         assign data_valid = ~empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q;
         logic                  dv_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dout_q <= '0;
               dv_q   <= 1'b0;
            end else begin
               dv_q <= rd_do;
               if (rd_do) dout_q <= mem[rd_ptr];
            end
         end

         assign data_out   = dout_q;
         assign data_valid = dv_q;
      end
   endgenerate

endmodule
